// File: rtl/wqe_dispatcher.sv
// WQE dispatcher: pops work-queue entries and programs the read/write DMA descriptor slaves.
// Optional per-WQE statistics counters are enabled with `define WQE_DISPATCH_STATS_EN.
module wqe_dispatcher #(
  parameter logic [4:0] OP_READ  = 5'd0,
  parameter logic [4:0] OP_WRITE = 5'd1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [115:0] fifoData,
  input  logic         fifoEmpty,
  output logic         fifoPop,
  output logic         RdDCSChipSelect_o,
  output logic         RdDCSWrite_o,
  output logic [7:0]   RdDCSAddress_o,
  output logic [31:0]  RdDCSWriteData_o,
  output logic [3:0]   RdDCSByteEnable_o,
  input  logic         RdDCSWaitRequest_i,
  output logic         WrDCSChipSelect_o,
  output logic         WrDCSWrite_o,
  output logic [7:0]   WrDCSAddress_o,
  output logic [31:0]  WrDCSWriteData_o,
  output logic [3:0]   WrDCSByteEnable_o,
  input  logic         WrDCSWaitRequest_i,
  output logic         busy,
  output logic         wqeDone,
  output logic         wqeError
`ifdef WQE_DISPATCH_STATS_EN
  ,
  output logic [15:0]  dispatchCount,
  output logic [15:0]  errorCount
`endif
);

  localparam int unsigned LEN_W  = 9;
  localparam int unsigned BLEN_W = 11;
  localparam int unsigned NSEG   = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_SEG, S_W0, S_W1, S_W2, S_W3, S_NEXT
  } state_t;

  state_t                      state_q, state_d;
  logic [4:0]                  opcode_q;
  logic [2:0]                  data_num_q;
  logic [7:0]                  tid_q;
  logic [NSEG-1:0][LEN_W-1:0]  len_q;
  logic [63:0]                 addr_q;
  logic [1:0]                  seg_q;
  logic [1:0]                  last_q;
  logic                        is_wr_q;
  logic                        done_q, done_d;
  logic                        error_q, error_d;

  logic                        fifo_pop;
  logic                        dec_err;
  logic                        any_len;
  logic [1:0]                  dec_last;
  logic [LEN_W-1:0]            seg_len;
  logic [BLEN_W-1:0]           byte_len;
  logic                        wait_sel;
  logic                        wr_en;
  logic [7:0]                  wr_addr;
  logic [31:0]                 wr_data;
  logic                        rd_sel, wr_sel;

  // No pop while reset is held or in the cycle a WQE retires, so the next pop follows the pulse.
  assign fifo_pop = (state_q == S_IDLE) & ~fifoEmpty & ~reset & ~done_q & ~error_q;
  assign fifoPop  = fifo_pop;
  assign busy     = (state_q != S_IDLE);
  assign wqeDone  = done_q;
  assign wqeError = error_q;

  assign seg_len  = len_q[seg_q];
  assign byte_len = {seg_len, 2'b00};
  assign wait_sel = is_wr_q ? WrDCSWaitRequest_i : RdDCSWaitRequest_i;

  // Entry validation and index of the last non-empty segment.
  always_comb begin
    any_len  = 1'b0;
    dec_last = 2'd0;
    for (int i = 0; i < int'(NSEG); i++) begin
      if ((3'(i) < data_num_q) && (len_q[i] != '0)) begin
        any_len  = 1'b1;
        dec_last = 2'(i);
      end
    end
    dec_err = ((opcode_q != OP_READ) && (opcode_q != OP_WRITE)) ||
              (data_num_q == 3'd0) || (data_num_q > 3'd4) || !any_len;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 8'h00;
    wr_data = 32'h0;
    case (state_q)
      S_IDLE:   if (fifo_pop) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_err) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_SEG;
        end
      end
      S_SEG:    state_d = (seg_len == '0) ? S_NEXT : S_W0;
      S_W0: begin
        wr_en   = 1'b1;
        wr_addr = 8'h00;
        wr_data = addr_q[31:0];
        if (!wait_sel) state_d = S_W1;
      end
      S_W1: begin
        wr_en   = 1'b1;
        wr_addr = 8'h04;
        wr_data = addr_q[63:32];
        if (!wait_sel) state_d = S_W2;
      end
      S_W2: begin
        wr_en   = 1'b1;
        wr_addr = 8'h08;
        wr_data = {tid_q, 2'b00, seg_q, 9'd0, byte_len};
        if (!wait_sel) state_d = S_W3;
      end
      S_W3: begin
        wr_en   = 1'b1;
        wr_addr = 8'h0C;
        wr_data = {1'b1, 30'd0, (seg_q == last_q)};
        if (!wait_sel) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (seg_q == last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_SEG;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Entry fields, segment cursor and running address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode_q   <= '0;
      data_num_q <= '0;
      tid_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      seg_q      <= '0;
      last_q     <= '0;
      is_wr_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= done_d;
      error_q <= error_d;
      if (fifo_pop) begin
        opcode_q   <= fifoData[115:111];
        data_num_q <= fifoData[110:108];
        tid_q      <= fifoData[107:100];
        len_q[0]   <= fifoData[99:91];
        len_q[1]   <= fifoData[90:82];
        len_q[2]   <= fifoData[81:73];
        len_q[3]   <= fifoData[72:64];
        addr_q     <= fifoData[63:0];
        is_wr_q    <= (fifoData[115:111] == OP_WRITE);
      end
      if (state_q == S_DECODE) begin
        seg_q  <= 2'd0;
        last_q <= dec_last;
      end
      if (state_q == S_NEXT) begin
        addr_q <= addr_q + 64'(byte_len);
        if (seg_q != last_q) seg_q <= seg_q + 2'd1;
      end
    end
  end

  assign rd_sel = wr_en & ~is_wr_q;
  assign wr_sel = wr_en &  is_wr_q;

  assign RdDCSChipSelect_o = rd_sel;
  assign RdDCSWrite_o      = rd_sel;
  assign RdDCSAddress_o    = rd_sel ? wr_addr : 8'h00;
  assign RdDCSWriteData_o  = rd_sel ? wr_data : 32'h0;
  assign RdDCSByteEnable_o = rd_sel ? 4'hF : 4'h0;

  assign WrDCSChipSelect_o = wr_sel;
  assign WrDCSWrite_o      = wr_sel;
  assign WrDCSAddress_o    = wr_sel ? wr_addr : 8'h00;
  assign WrDCSWriteData_o  = wr_sel ? wr_data : 32'h0;
  assign WrDCSByteEnable_o = wr_sel ? 4'hF : 4'h0;

`ifdef WQE_DISPATCH_STATS_EN
  // Saturating completion and drop counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dispatchCount <= '0;
      errorCount    <= '0;
    end else begin
      if (done_d && (dispatchCount != 16'hFFFF)) dispatchCount <= dispatchCount + 16'd1;
      if (error_d && (errorCount != 16'hFFFF))   errorCount    <= errorCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wqe_dispatcher.sv
// Directed bench for wqe_dispatcher: FIFO model, Avalon write logger and stall injector.
module tb_wqe_dispatcher;

  logic         clock = 1'b0;
  logic         reset;
  logic [115:0] fifoData;
  logic         fifoEmpty;
  logic         fifoPop;
  logic         RdDCSChipSelect_o, RdDCSWrite_o;
  logic [7:0]   RdDCSAddress_o;
  logic [31:0]  RdDCSWriteData_o;
  logic [3:0]   RdDCSByteEnable_o;
  logic         RdDCSWaitRequest_i = 1'b0;
  logic         WrDCSChipSelect_o, WrDCSWrite_o;
  logic [7:0]   WrDCSAddress_o;
  logic [31:0]  WrDCSWriteData_o;
  logic [3:0]   WrDCSByteEnable_o;
  logic         WrDCSWaitRequest_i = 1'b0;
  logic         busy, wqeDone, wqeError;
`ifdef WQE_DISPATCH_STATS_EN
  logic [15:0]  dispatchCount, errorCount;
`endif

  wqe_dispatcher dut (
    .clock(clock), .reset(reset),
    .fifoData(fifoData), .fifoEmpty(fifoEmpty), .fifoPop(fifoPop),
    .RdDCSChipSelect_o(RdDCSChipSelect_o), .RdDCSWrite_o(RdDCSWrite_o),
    .RdDCSAddress_o(RdDCSAddress_o), .RdDCSWriteData_o(RdDCSWriteData_o),
    .RdDCSByteEnable_o(RdDCSByteEnable_o), .RdDCSWaitRequest_i(RdDCSWaitRequest_i),
    .WrDCSChipSelect_o(WrDCSChipSelect_o), .WrDCSWrite_o(WrDCSWrite_o),
    .WrDCSAddress_o(WrDCSAddress_o), .WrDCSWriteData_o(WrDCSWriteData_o),
    .WrDCSByteEnable_o(WrDCSByteEnable_o), .WrDCSWaitRequest_i(WrDCSWaitRequest_i),
    .busy(busy), .wqeDone(wqeDone), .wqeError(wqeError)
`ifdef WQE_DISPATCH_STATS_EN
    , .dispatchCount(dispatchCount), .errorCount(errorCount)
`endif
  );

  always #5 clock = ~clock;

  // Show-ahead FIFO model
  logic [115:0] mem [16];
  logic [3:0]   wr_ptr = 4'd0;
  logic [3:0]   rd_ptr = 4'd0;
  assign fifoEmpty = (rd_ptr == wr_ptr);
  assign fifoData  = mem[rd_ptr];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_n = 0;
  int pop_cyc [32];
  int done_n = 0;
  int done_cyc [32];
  int err_n = 0;
  int wr_n = 0;
  logic        lg_port [64];
  logic [7:0]  lg_addr [64];
  logic [31:0] lg_data [64];
  logic [3:0]  lg_be   [64];
  int          lg_cyc  [64];
  int rd_act = 0;
  int wr_act = 0;
  int stall_cfg = 0;
  int stall_run = 0;
  int held_n = 0;
  int held_bad = 0;
  logic        prev08 = 1'b0;
  logic [31:0] prev_d = 32'h0;

  // Pops are taken at the edge that consumes the head entry
  always @(posedge clock) begin
    if (fifoPop) begin
      pop_cyc[pop_n] = cyc;
      pop_n++;
      rd_ptr <= rd_ptr + 4'd1;
    end
    cyc++;
  end

  // Mid-cycle: drive waitrequest for the coming edge, then log completed writes and pulses
  always @(negedge clock) begin
    if (reset) begin
      RdDCSWaitRequest_i = 1'b0;
      WrDCSWaitRequest_i = 1'b0;
      stall_run = 0;
      prev08 = 1'b0;
    end else begin
      if (RdDCSChipSelect_o && RdDCSAddress_o == 8'h08) begin
        RdDCSWaitRequest_i = (stall_run < stall_cfg);
        stall_run++;
        held_n++;
        if (prev08 && RdDCSWriteData_o !== prev_d) held_bad++;
        prev08 = 1'b1;
        prev_d = RdDCSWriteData_o;
      end else begin
        RdDCSWaitRequest_i = 1'b0;
        stall_run = 0;
        prev08 = 1'b0;
      end
      WrDCSWaitRequest_i = 1'b0;
      if (RdDCSChipSelect_o || RdDCSWrite_o) rd_act++;
      if (WrDCSChipSelect_o || WrDCSWrite_o) wr_act++;
      if (RdDCSChipSelect_o && RdDCSWrite_o && !RdDCSWaitRequest_i) begin
        lg_port[wr_n] = 1'b0; lg_addr[wr_n] = RdDCSAddress_o; lg_data[wr_n] = RdDCSWriteData_o;
        lg_be[wr_n] = RdDCSByteEnable_o; lg_cyc[wr_n] = cyc; wr_n++;
      end
      if (WrDCSChipSelect_o && WrDCSWrite_o && !WrDCSWaitRequest_i) begin
        lg_port[wr_n] = 1'b1; lg_addr[wr_n] = WrDCSAddress_o; lg_data[wr_n] = WrDCSWriteData_o;
        lg_be[wr_n] = WrDCSByteEnable_o; lg_cyc[wr_n] = cyc; wr_n++;
      end
      if (wqeDone) begin
        done_cyc[done_n] = cyc;
        done_n++;
      end
      if (wqeError) err_n++;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic port,
                          input logic [7:0] addr, input logic [31:0] data);
    check({tag, "_port"}, 64'(lg_port[idx]), 64'(port));
    check({tag, "_addr"}, 64'(lg_addr[idx]), 64'(addr));
    check({tag, "_data"}, 64'(lg_data[idx]), 64'(data));
    check({tag, "_be"},   64'(lg_be[idx]),   64'(4'hF));
  endtask

  function automatic logic [115:0] mk(input logic [4:0] op, input logic [2:0] num,
                                      input logic [7:0] tid, input logic [8:0] l0,
                                      input logic [8:0] l1, input logic [8:0] l2,
                                      input logic [8:0] l3, input logic [63:0] base);
    return {op, num, tid, l0, l1, l2, l3, base};
  endfunction

  task automatic push(input logic [115:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic wait_done(input int dn, input int en, input int budget);
    int k = 0;
    while ((done_n < dn || err_n < en || busy || !fifoEmpty) && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    n_vec++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL timeout: waited %0d cycles, done %0d/%0d errors %0d/%0d", k, done_n, dn, err_n, en);
    end
    repeat (2) begin @(negedge clock); #1; end
  endtask

  int b, p, d, e, ra, wa, hn, hb, k;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("reset_outs", 64'({fifoPop, busy, wqeDone, wqeError, RdDCSChipSelect_o, RdDCSWrite_o,
                              WrDCSChipSelect_o, WrDCSWrite_o, RdDCSByteEnable_o, WrDCSByteEnable_o}), 64'd0);
`ifdef WQE_DISPATCH_STATS_EN
    check("reset_cnt", 64'({dispatchCount, errorCount}), 64'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // READ, one segment
    b = wr_n; p = pop_n; d = done_n; e = err_n; ra = rd_act; wa = wr_act;
    push(mk(5'd0, 3'd1, 8'h5A, 9'd16, 9'd0, 9'd0, 9'd0, 64'h0000_0001_FFFF_FFF0));
    wait_done(d + 1, e, 100);
    check("t1_nwr", 64'(wr_n - b), 64'd4);
    check_wr("t1_w0", b,     1'b0, 8'h00, 32'hFFFF_FFF0);
    check_wr("t1_w1", b + 1, 1'b0, 8'h04, 32'h0000_0001);
    check_wr("t1_w2", b + 2, 1'b0, 8'h08, 32'h5A00_0040);
    check_wr("t1_w3", b + 3, 1'b0, 8'h0C, 32'h8000_0001);
    check("t1_w0_lat", 64'(lg_cyc[b] - pop_cyc[p]), 64'd3);
    check("t1_done_lat", 64'(done_cyc[d] - pop_cyc[p]), 64'd8);
    check("t1_wrdcs_idle", 64'(wr_act - wa), 64'd0);
    check("t1_pops", 64'(pop_n - p), 64'd1);

    // WRITE, three segments with a zero-length middle one and 64-bit wrap
    b = wr_n; p = pop_n; d = done_n; ra = rd_act;
    push(mk(5'd1, 3'd3, 8'h3C, 9'd4, 9'd0, 9'd8, 9'd0, 64'hFFFF_FFFF_FFFF_FFF8));
    wait_done(d + 1, e, 100);
    check("t2_nwr", 64'(wr_n - b), 64'd8);
    check_wr("t2_s0w0", b,     1'b1, 8'h00, 32'hFFFF_FFF8);
    check_wr("t2_s0w1", b + 1, 1'b1, 8'h04, 32'hFFFF_FFFF);
    check_wr("t2_s0w2", b + 2, 1'b1, 8'h08, 32'h3C00_0010);
    check_wr("t2_s0w3", b + 3, 1'b1, 8'h0C, 32'h8000_0000);
    check_wr("t2_s2w0", b + 4, 1'b1, 8'h00, 32'h0000_0008);
    check_wr("t2_s2w1", b + 5, 1'b1, 8'h04, 32'h0000_0000);
    check_wr("t2_s2w2", b + 6, 1'b1, 8'h08, 32'h3C20_0020);
    check_wr("t2_s2w3", b + 7, 1'b1, 8'h0C, 32'h8000_0001);
    check("t2_done_lat", 64'(done_cyc[d] - pop_cyc[p]), 64'd16);
    check("t2_rddcs_idle", 64'(rd_act - ra), 64'd0);

    // Three-cycle stall on W2
    b = wr_n; p = pop_n; d = done_n; hn = held_n; hb = held_bad;
    stall_cfg = 3;
    push(mk(5'd0, 3'd1, 8'h5A, 9'd16, 9'd0, 9'd0, 9'd0, 64'h0000_0001_FFFF_FFF0));
    wait_done(d + 1, e, 100);
    stall_cfg = 0;
    check("t3_nwr", 64'(wr_n - b), 64'd4);
    check("t3_held_cycles", 64'(held_n - hn), 64'd4);
    check("t3_held_changes", 64'(held_bad - hb), 64'd0);
    check_wr("t3_w2", b + 2, 1'b0, 8'h08, 32'h5A00_0040);
    check("t3_w3_lat", 64'(lg_cyc[b + 3] - pop_cyc[p]), 64'd9);
    check("t3_done_lat", 64'(done_cyc[d] - pop_cyc[p]), 64'd11);

    // Dropped entries: bad opcode, zero count, all in-range lengths zero
    b = wr_n; p = pop_n; d = done_n; e = err_n; ra = rd_act; wa = wr_act;
    push(mk(5'd7, 3'd1, 8'h01, 9'd4, 9'd0, 9'd0, 9'd0, 64'h100));
    push(mk(5'd0, 3'd0, 8'h02, 9'd4, 9'd4, 9'd0, 9'd0, 64'h200));
    push(mk(5'd1, 3'd2, 8'h03, 9'd0, 9'd0, 9'd5, 9'd0, 64'h300));
    wait_done(d, e + 3, 100);
    check("t4_errors", 64'(err_n - e), 64'd3);
    check("t4_pops", 64'(pop_n - p), 64'd3);
    check("t4_dones", 64'(done_n - d), 64'd0);
    check("t4_strobes", 64'((rd_act - ra) + (wr_act - wa) + (wr_n - b)), 64'd0);
    check("t4_pop_gap", 64'(pop_cyc[p + 1] - pop_cyc[p]), 64'd3);
`ifdef WQE_DISPATCH_STATS_EN
    check("t4_errorCount", 64'(errorCount), 64'd3);
    check("t4_dispatchCount", 64'(dispatchCount), 64'd3);
`endif

    // Back-to-back valid entries
    b = wr_n; p = pop_n; d = done_n; e = err_n;
    push(mk(5'd0, 3'd1, 8'h11, 9'd1, 9'd0, 9'd0, 9'd0, 64'h1000));
    push(mk(5'd0, 3'd1, 8'h22, 9'd1, 9'd0, 9'd0, 9'd0, 64'h2000));
    wait_done(d + 2, e, 100);
    check("t5_pops", 64'(pop_n - p), 64'd2);
    check("t5_pop_after_done", 64'(pop_cyc[p + 1] - done_cyc[d]), 64'd1);
    check("t5_done2_lat", 64'(done_cyc[d + 1] - pop_cyc[p + 1]), 64'd8);
    check("t5_nwr", 64'(wr_n - b), 64'd8);
    check_wr("t5_b_w2", b + 6, 1'b0, 8'h08, 32'h2200_0004);

    // Reset while W1 of the first entry is on the bus
    b = wr_n; p = pop_n; d = done_n; e = err_n;
    push(mk(5'd0, 3'd1, 8'h33, 9'd2, 9'd0, 9'd0, 9'd0, 64'h0000_0000_0000_5000));
    push(mk(5'd0, 3'd1, 8'h44, 9'd1, 9'd0, 9'd0, 9'd0, 64'h0000_0000_0000_3000));
    k = 0;
    while (!(RdDCSChipSelect_o && RdDCSAddress_o == 8'h04) && k < 50) begin
      @(negedge clock); #1;
      k++;
    end
    check("t6_reached_w1", 64'(k < 50), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_strobes_in_reset", 64'({RdDCSChipSelect_o, RdDCSWrite_o, WrDCSChipSelect_o, WrDCSWrite_o,
                                       RdDCSByteEnable_o, busy, fifoPop}), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("t6_idle_after", 64'({busy, fifoPop}), 64'b01);
    wait_done(d + 1, e, 100);
    check("t6_pops", 64'(pop_n - p), 64'd2);
    check("t6_dones", 64'(done_n - d), 64'd1);
    check("t6_nwr", 64'(wr_n - b), 64'd6);
    check_wr("t6_b_w0", b + 2, 1'b0, 8'h00, 32'h0000_3000);
    check_wr("t6_b_w2", b + 4, 1'b0, 8'h08, 32'h4400_0004);
`ifdef WQE_DISPATCH_STATS_EN
    check("t6_counts", 64'({dispatchCount, errorCount}), 64'h0001_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
